sys_axi_master: RTL and testbench

- Simple system-bus-to-AXI3 master bridge. The opposite end of the AXI slave that feeds the simple RP bus.
- Accepts one single-cycle write or read request from a simple bus initiator (e.g. a DMA or control sequencer) and issues one single-beat AXI transaction.
- Returns ack, read data and an error flag to the initiator.
- Sits between internal initiators and the AXI interconnect / PS slave port.

---
 rtl/sys_axi_master.sv | 273 +++++++++++++++++++++++++++
 tb/tb_sys_axi_master.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_axi_master.sv
// Simple-bus to AXI3 master bridge: one request in, one single-beat AXI
// transaction out, with a watchdog that forces an error ack on a stuck slave.
module sys_axi_master #(
  parameter int AXI_DW  = 32,
  parameter int AXI_AW  = 32,
  parameter int AXI_IW  = 8,
  parameter int AXI_SW  = AXI_DW >> 3,
  parameter int AXI_ID  = 0,
  parameter int TIMEOUT = 32
) (
  input  logic              axi_clk_i,
  input  logic              axi_rst_i,
  // simple system bus
  input  logic [AXI_AW-1:0] sys_addr_i,
  input  logic [AXI_DW-1:0] sys_wdata_i,
  input  logic [AXI_SW-1:0] sys_sel_i,
  input  logic              sys_wen_i,
  input  logic              sys_ren_i,
  output logic [AXI_DW-1:0] sys_rdata_o,
  output logic              sys_ack_o,
  output logic              sys_err_o,
  output logic              sys_busy_o,
  // write address
  output logic [AXI_IW-1:0] axi_awid_o,
  output logic [AXI_AW-1:0] axi_awaddr_o,
  output logic [3:0]        axi_awlen_o,
  output logic [2:0]        axi_awsize_o,
  output logic [1:0]        axi_awburst_o,
  output logic              axi_awvalid_o,
  input  logic              axi_awready_i,
  // write data
  output logic [AXI_IW-1:0] axi_wid_o,
  output logic [AXI_DW-1:0] axi_wdata_o,
  output logic [AXI_SW-1:0] axi_wstrb_o,
  output logic              axi_wlast_o,
  output logic              axi_wvalid_o,
  input  logic              axi_wready_i,
  // write response
  input  logic [AXI_IW-1:0] axi_bid_i,
  input  logic [1:0]        axi_bresp_i,
  input  logic              axi_bvalid_i,
  output logic              axi_bready_o,
  // read address
  output logic [AXI_IW-1:0] axi_arid_o,
  output logic [AXI_AW-1:0] axi_araddr_o,
  output logic [3:0]        axi_arlen_o,
  output logic [2:0]        axi_arsize_o,
  output logic [1:0]        axi_arburst_o,
  output logic              axi_arvalid_o,
  input  logic              axi_arready_i,
  // read data
  input  logic [AXI_IW-1:0] axi_rid_i,
  input  logic [AXI_DW-1:0] axi_rdata_i,
  input  logic [1:0]        axi_rresp_i,
  input  logic              axi_rlast_i,
  input  logic              axi_rvalid_i,
  output logic              axi_rready_o
);

  localparam logic [2:0]        AXI_SIZE = 3'($clog2(AXI_SW));
  localparam logic [AXI_IW-1:0] ID_VAL   = AXI_IW'(AXI_ID);
  localparam logic [7:0]        TO_VAL   = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [AXI_AW-1:0] addr_q, addr_d;
  logic [AXI_DW-1:0] wdata_q, wdata_d;
  logic [AXI_SW-1:0] sel_q, sel_d;
  logic              is_wr_q, is_wr_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [AXI_DW-1:0] rdata_q, rdata_d;
  logic [7:0]        cnt_q, cnt_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_left, w_left;
  logic done, resp_err;

  assign aw_hs   = awvalid_q & axi_awready_i;
  assign w_hs    = wvalid_q  & axi_wready_i;
  assign b_hs    = bready_q  & axi_bvalid_i;
  assign ar_hs   = arvalid_q & axi_arready_i;
  assign r_hs    = rready_q  & axi_rvalid_i;
  assign aw_left = awvalid_q & ~axi_awready_i;
  assign w_left  = wvalid_q  & ~axi_wready_i;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    is_wr_d   = is_wr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    done      = 1'b0;
    resp_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (sys_wen_i || sys_ren_i) begin
          addr_d  = sys_addr_i;
          wdata_d = sys_wdata_i;
          sel_d   = sys_sel_i;
          busy_d  = 1'b1;
          cnt_d   = 8'd1;
          is_wr_d = sys_wen_i;
          if (sys_wen_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (!aw_left && !w_left) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          bready_d = 1'b0;
          done     = 1'b1;
          resp_err = axi_bresp_i[1] | (axi_bid_i != ID_VAL);
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          rready_d = 1'b0;
          rdata_d  = axi_rdata_i;
          done     = 1'b1;
          resp_err = axi_rresp_i[1] | (axi_rid_i != ID_VAL) | ~axi_rlast_i;
        end
      end
      DRAIN: begin
        // Finish whatever is still open on the AXI side, silently.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
        if (is_wr_q && !aw_left && !w_left && !bready_q) bready_d = 1'b1;
        if (b_hs || r_hs) begin
          bready_d = 1'b0;
          rready_d = 1'b0;
          busy_d   = 1'b0;
          cnt_d    = 8'd0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A response arriving on the timeout cycle takes precedence.
    if (state_q inside {WR, WR_RESP, RD_ADDR, RD_DATA}) begin
      if (done) begin
        ack_d   = 1'b1;
        err_d   = resp_err;
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == TO_VAL) begin
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = DRAIN;
        end
      end
    end
  end

  always_ff @(posedge axi_clk_i or posedge axi_rst_i) begin
    if (axi_rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      is_wr_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      is_wr_q   <= is_wr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign sys_rdata_o   = rdata_q;
  assign sys_ack_o     = ack_q;
  assign sys_err_o     = err_q;
  assign sys_busy_o    = busy_q;

  assign axi_awid_o    = ID_VAL;
  assign axi_awaddr_o  = addr_q;
  assign axi_awlen_o   = 4'd0;
  assign axi_awsize_o  = AXI_SIZE;
  assign axi_awburst_o = 2'b01;
  assign axi_awvalid_o = awvalid_q;

  assign axi_wid_o     = ID_VAL;
  assign axi_wdata_o   = wdata_q;
  assign axi_wstrb_o   = sel_q;
  assign axi_wlast_o   = 1'b1;
  assign axi_wvalid_o  = wvalid_q;

  assign axi_bready_o  = bready_q;

  assign axi_arid_o    = ID_VAL;
  assign axi_araddr_o  = addr_q;
  assign axi_arlen_o   = 4'd0;
  assign axi_arsize_o  = AXI_SIZE;
  assign axi_arburst_o = 2'b01;
  assign axi_arvalid_o = arvalid_q;

  assign axi_rready_o  = rready_q;

endmodule

// File: tb/tb_sys_axi_master.sv
// Bench for sys_axi_master: reactive AXI slave with per-channel delays, and a
// scoreboard that checks every AXI handshake and every ack against expectations.
module tb_sys_axi_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int SW = 4;
  localparam int ID = 0;
  localparam int TO = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] sys_addr;
  logic [DW-1:0] sys_wdata;
  logic [SW-1:0] sys_sel;
  logic          sys_wen, sys_ren;
  logic [DW-1:0] sys_rdata;
  logic          sys_ack, sys_err, sys_busy;
  logic [IW-1:0] awid, wid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [3:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;

  sys_axi_master #(
    .AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_SW(SW), .AXI_ID(ID), .TIMEOUT(TO)
  ) dut (
    .axi_clk_i(clk), .axi_rst_i(rst),
    .sys_addr_i(sys_addr), .sys_wdata_i(sys_wdata), .sys_sel_i(sys_sel),
    .sys_wen_i(sys_wen), .sys_ren_i(sys_ren), .sys_rdata_o(sys_rdata),
    .sys_ack_o(sys_ack), .sys_err_o(sys_err), .sys_busy_o(sys_busy),
    .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen), .axi_awsize_o(awsize),
    .axi_awburst_o(awburst), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .axi_wid_o(wid), .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
    .axi_wvalid_o(wvalid), .axi_wready_i(wready),
    .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
    .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
    .axi_arburst_o(arburst), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
    .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // slave configuration, changed by the stimulus thread between transactions
  int            aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]    b_resp = 2'b00, r_resp = 2'b00;
  logic [IW-1:0] b_id = '0, r_id = '0;
  logic [DW-1:0] r_data = '0;
  logic          r_last = 1'b1;
  int            aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

  typedef struct packed {
    logic          err;
    logic          busy;
    logic [DW-1:0] rdata;
  } ack_t;

  logic [AW-1:0]    exp_aw[$];
  logic [DW+SW-1:0] exp_w[$];
  logic [AW-1:0]    exp_ar[$];
  ack_t             exp_ack[$];
  logic [DW-1:0]    model_rdata = '0;

  int   ack_cnt = 0, ack_cyc = 0, req_cyc = 0, ar_hi_cnt = 0;
  logic prev_ack = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: event occurred that was not expected", name);
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  // AXI slave: each ready/valid is raised a configurable number of cycles late
  initial begin
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bid = '0; bresp = '0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (awvalid && !awready) begin
          if (aw_cnt >= aw_dly) awready = 1; else aw_cnt++;
        end else if (awready) begin awready = 0; aw_cnt = 0; end
        if (wvalid && !wready) begin
          if (w_cnt >= w_dly) wready = 1; else w_cnt++;
        end else if (wready) begin wready = 0; w_cnt = 0; end
        if (arvalid && !arready) begin
          if (ar_cnt >= ar_dly) arready = 1; else ar_cnt++;
        end else if (arready) begin arready = 0; ar_cnt = 0; end
        if (bready && !bvalid) begin
          if (b_cnt >= b_dly) begin bvalid = 1; bresp = b_resp; bid = b_id; end
          else b_cnt++;
        end else if (bvalid && !bready) begin bvalid = 0; b_cnt = 0; end
        if (rready && !rvalid) begin
          if (r_cnt >= r_dly) begin
            rvalid = 1; rdata = r_data; rresp = r_resp; rid = r_id; rlast = r_last;
          end else r_cnt++;
        end else if (rvalid && !rready) begin rvalid = 0; r_cnt = 0; end
      end
    end
  end

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (arvalid) ar_hi_cnt++;
        if (awvalid && awready) begin
          if (exp_aw.size() == 0) fail_now("aw_unexpected");
          else begin
            check_output("awaddr", awaddr, exp_aw.pop_front());
            check_output("aw_const", {awid, awlen, awsize, awburst}, {8'(ID), 4'd0, 3'd2, 2'b01});
          end
        end
        if (wvalid && wready) begin
          if (exp_w.size() == 0) fail_now("w_unexpected");
          else begin
            check_output("wdata_wstrb", {wdata, wstrb}, exp_w.pop_front());
            check_output("w_const", {wid, wlast}, {8'(ID), 1'b1});
          end
        end
        if (arvalid && arready) begin
          if (exp_ar.size() == 0) fail_now("ar_unexpected");
          else begin
            check_output("araddr", araddr, exp_ar.pop_front());
            check_output("ar_const", {arid, arlen, arsize, arburst}, {8'(ID), 4'd0, 3'd2, 2'b01});
          end
        end
        if (sys_ack) begin
          ack_cnt++;
          ack_cyc = cyc;
          check_output("ack_single_cycle", prev_ack, 0);
          if (exp_ack.size() == 0) fail_now("ack_unexpected");
          else begin
            ack_t e;
            e = exp_ack.pop_front();
            check_output("ack_err", sys_err, e.err);
            check_output("ack_busy", sys_busy, e.busy);
            check_output("ack_rdata", sys_rdata, e.rdata);
          end
        end
        prev_ack = sys_ack;
      end else prev_ack = 1'b0;
    end
  end

  task automatic apply_stimulus(input logic wen, input logic ren, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wd, input logic [SW-1:0] sel);
    sys_wen = wen; sys_ren = ren; sys_addr = addr; sys_wdata = wd; sys_sel = sel;
    req_cyc = cyc;
    tick();
    sys_wen = 0; sys_ren = 0;
  endtask

  task automatic expect_write(input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                              input logic [SW-1:0] sel, input logic err);
    exp_aw.push_back(addr);
    exp_w.push_back({wd, sel});
    exp_ack.push_back('{err: err, busy: 1'b0, rdata: model_rdata});
  endtask

  task automatic expect_read(input logic [AW-1:0] addr, input logic [DW-1:0] rd, input logic err);
    model_rdata = rd;
    exp_ar.push_back(addr);
    exp_ack.push_back('{err: err, busy: 1'b0, rdata: rd});
  endtask

  task automatic wait_acks(input int target, input int budget, input int lat);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (ack_cnt < target) fail_now("ack_wait_expired");
    else if (lat >= 0) check_output("ack_latency", ack_cyc - req_cyc, lat);
  endtask

  initial begin
    int a0, aw_hi, w_hi, bad, n;
    rst = 1; sys_wen = 0; sys_ren = 0; sys_addr = '0; sys_wdata = '0; sys_sel = '0;
    repeat (3) tick();
    check_output("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    check_output("rst_ack_err_busy", {sys_ack, sys_err, sys_busy}, 0);
    check_output("rst_rdata", sys_rdata, 0);
    rst = 0;
    tick();

    // zero-wait write and read, then a back-to-back read
    expect_write(32'h1000_0004, 32'h1122_3344, 4'hF, 0);
    apply_stimulus(1, 0, 32'h1000_0004, 32'h1122_3344, 4'hF);
    wait_acks(1, 20, 3);
    tick();
    r_data = 32'hCAFE_F00D;
    expect_read(32'h1000_0008, 32'hCAFE_F00D, 0);
    apply_stimulus(0, 1, 32'h1000_0008, '0, '0);
    wait_acks(2, 20, 3);
    tick();
    r_data = 32'h0102_0304;
    expect_read(32'h1000_000C, 32'h0102_0304, 0);
    apply_stimulus(0, 1, 32'h1000_000C, '0, '0);
    wait_acks(3, 20, 3);

    // write with delayed B
    tick();
    b_dly = 1;
    expect_write(32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    apply_stimulus(1, 0, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF);
    wait_acks(4, 20, 4);
    tick();
    check_output("busy_after_write", sys_busy, 0);

    // AW accepted at once, W held four cycles
    b_dly = 0; w_dly = 3;
    expect_write(32'h4000_0014, 32'h0000_BEEF, 4'h3, 0);
    a0 = ack_cnt;
    apply_stimulus(1, 0, 32'h4000_0014, 32'h0000_BEEF, 4'h3);
    aw_hi = 0; w_hi = 0; bad = 0; n = 0;
    while (ack_cnt == a0 && n < 30) begin
      aw_hi += int'(awvalid);
      w_hi  += int'(wvalid);
      if (bready && (awvalid || wvalid)) bad++;
      tick();
      n++;
    end
    if (ack_cnt == a0) fail_now("ack_wait_expired");
    check_output("awvalid_cycles", aw_hi, 1);
    check_output("wvalid_cycles", w_hi, 4);
    check_output("bready_early", bad, 0);
    check_output("ack_latency", ack_cyc - req_cyc, 6);
    w_dly = 0;

    // read with delayed AR, then error responses
    tick();
    ar_dly = 2; r_data = 32'h1234_5678;
    expect_read(32'h4000_0020, 32'h1234_5678, 0);
    apply_stimulus(0, 1, 32'h4000_0020, '0, '0);
    wait_acks(6, 20, 5);
    ar_dly = 0;
    tick();
    r_resp = 2'b10; r_data = 32'hA5A5_A5A5;
    expect_read(32'h4000_0024, 32'hA5A5_A5A5, 1);
    apply_stimulus(0, 1, 32'h4000_0024, '0, '0);
    wait_acks(7, 20, 3);
    tick();
    r_resp = 2'b00; r_id = 8'(ID + 1); r_data = 32'h0BAD_F00D;
    expect_read(32'h4000_0028, 32'h0BAD_F00D, 1);
    apply_stimulus(0, 1, 32'h4000_0028, '0, '0);
    wait_acks(8, 20, 3);
    tick();
    r_id = 8'(ID); r_last = 0; r_data = 32'h600D_CAFE;
    expect_read(32'h4000_002C, 32'h600D_CAFE, 1);
    apply_stimulus(0, 1, 32'h4000_002C, '0, '0);
    wait_acks(9, 20, 3);
    r_last = 1;
    tick();
    b_resp = 2'b10;
    expect_write(32'h4000_0030, 32'h5555_AAAA, 4'h8, 1);
    apply_stimulus(1, 0, 32'h4000_0030, 32'h5555_AAAA, 4'h8);
    wait_acks(10, 20, 3);
    tick();
    b_resp = 2'b01;
    expect_write(32'h4000_0034, 32'h0F0F_0F0F, 4'h1, 0);
    apply_stimulus(1, 0, 32'h4000_0034, 32'h0F0F_0F0F, 4'h1);
    wait_acks(11, 20, 3);
    tick();
    b_resp = 2'b00; b_id = 8'(ID + 1);
    expect_write(32'h4000_0038, 32'h7777_8888, 4'hF, 1);
    apply_stimulus(1, 0, 32'h4000_0038, 32'h7777_8888, 4'hF);
    wait_acks(12, 20, 3);
    b_id = 8'(ID);

    // simultaneous wen/ren, plus a read request while busy
    tick();
    b_dly = 3;
    a0 = ack_cnt;
    n = ar_hi_cnt;
    expect_write(32'h4000_0040, 32'hABCD_0123, 4'hC, 0);
    apply_stimulus(1, 1, 32'h4000_0040, 32'hABCD_0123, 4'hC);
    apply_stimulus(0, 1, 32'h5000_0000, '0, '0);
    wait_acks(a0 + 1, 20, -1);
    repeat (8) tick();
    check_output("wen_ren_ack_count", ack_cnt - a0, 1);
    check_output("wen_ren_no_arvalid", ar_hi_cnt - n, 0);
    b_dly = 0;

    // stuck B channel: forced error ack, then drain
    tick();
    b_dly = 38;
    a0 = ack_cnt;
    exp_aw.push_back(32'h4000_0050);
    exp_w.push_back({32'h9999_0000, 4'hF});
    exp_ack.push_back('{err: 1'b1, busy: 1'b1, rdata: model_rdata});
    apply_stimulus(1, 0, 32'h4000_0050, 32'h9999_0000, 4'hF);
    wait_acks(a0 + 1, 45, TO);
    bad = 0;
    while (cyc < req_cyc + 41 && cyc < req_cyc + 100) begin
      if (!sys_busy) bad++;
      tick();
    end
    check_output("timeout_busy_held", bad, 0);
    check_output("timeout_busy_clear", sys_busy, 0);
    check_output("timeout_single_ack", ack_cnt - a0, 1);
    b_dly = 0;
    tick();
    r_data = 32'h3141_5926;
    expect_read(32'h4000_0054, 32'h3141_5926, 0);
    apply_stimulus(0, 1, 32'h4000_0054, '0, '0);
    wait_acks(a0 + 2, 20, 3);

    // reset in the middle of a write abandons it
    tick();
    b_dly = 20;
    a0 = ack_cnt;
    exp_aw.push_back(32'h4000_0060);
    exp_w.push_back({32'h2468_ACE0, 4'hF});
    apply_stimulus(1, 0, 32'h4000_0060, 32'h2468_ACE0, 4'hF);
    repeat (3) tick();
    rst = 1;
    tick();
    check_output("midrst_outputs", {sys_ack, sys_busy, bready, awvalid, wvalid}, 0);
    check_output("midrst_rdata", sys_rdata, 0);
    model_rdata = '0;
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_ack.delete();
    rst = 0;
    b_dly = 0;
    repeat (10) tick();
    check_output("midrst_no_ack", ack_cnt - a0, 0);
    r_data = 32'h2718_2818;
    expect_read(32'h4000_0064, 32'h2718_2818, 0);
    apply_stimulus(0, 1, 32'h4000_0064, '0, '0);
    wait_acks(a0 + 1, 20, 3);

    repeat (3) tick();
    check_output("pending_expectations", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_ack.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got no end, expected end");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
